flash_op_arb: RTL and testbench

//  Arbitrates flash access between the host read port and the controller (software) op port.

---
 rtl/flash_op_arb.sv | 208 ++++++++++++++++++++
 tb/tb_flash_op_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_op_arb.sv
// Flash op arbiter: grants host single-word reads or controller read/program/erase
// sequences into the MP stage. Optional macro FLASH_ARB_RR_EN enables round-robin arbitration.
module flash_op_arb #(
  parameter int BankW    = 1,
  parameter int PageW    = 8,
  parameter int WordW    = 8,
  parameter int TimeoutW = 12,
  localparam int AllPagesW = BankW + PageW,
  localparam int AW        = AllPagesW + WordW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hst_req_i,
  input  logic [AW-1:0]        hst_addr_i,
  output logic                 hst_gnt_o,
  output logic                 hst_done_o,
  output logic                 hst_err_o,
  input  logic                 ctrl_req_i,
  input  logic [1:0]           ctrl_op_i,
  input  logic                 ctrl_erase_sel_i,
  input  logic [AW-1:0]        ctrl_addr_i,
  input  logic [WordW:0]       ctrl_num_i,
  output logic                 ctrl_gnt_o,
  output logic                 ctrl_wdone_o,
  output logic                 ctrl_done_o,
  output logic                 ctrl_err_o,
  output logic                 busy_o,
  output logic                 req_o,
  output logic [AllPagesW-1:0] req_addr_o,
  output logic [BankW-1:0]     req_bk_o,
  output logic                 addr_ovfl_o,
  output logic                 rd_o,
  output logic                 prog_o,
  output logic                 pg_erase_o,
  output logic                 bk_erase_o,
  input  logic                 rd_done_i,
  input  logic                 prog_done_i,
  input  logic                 erase_done_i,
  input  logic                 error_i
);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StIssue,
    StNext,
    StFin
  } state_e;

  localparam logic [1:0]          OpRead  = 2'd0;
  localparam logic [1:0]          OpProg  = 2'd1;
  localparam logic [1:0]          OpErase = 2'd2;
  localparam logic [TimeoutW-1:0] WdogMax = '1;
  localparam logic [WordW:0]      NumMax  = {1'b0, {WordW{1'b1}}};

  state_e              state_q, state_d;
  logic                host_sel_q;
  logic [1:0]          op_q;
  logic                erase_bk_q;
  logic [AW-1:0]       addr_q;
  logic [WordW:0]      num_q;
  logic [WordW:0]      cnt_q;
  logic [TimeoutW-1:0] wdog_q;
  logic                err_q;
  logic                ovfl_q;

  logic                pick_host;
  logic                bad_req;
  logic                match;
  logic                timeout;
  logic                last_word;
  logic [AW:0]         addr_inc;

`ifdef FLASH_ARB_RR_EN
  // rr_ptr_q set means the controller has priority on the next simultaneous request.
  logic rr_ptr_q;
  assign pick_host = hst_req_i && !(ctrl_req_i && rr_ptr_q);
`else
  assign pick_host = hst_req_i;
`endif

  assign bad_req   = (ctrl_op_i == 2'd3) || ((ctrl_op_i != OpErase) && (ctrl_num_i > NumMax));
  assign timeout   = (wdog_q == WdogMax);
  assign last_word = host_sel_q || (op_q == OpErase) || (cnt_q == num_q);
  assign addr_inc  = {1'b0, addr_q} + (AW+1)'(1);

  always_comb begin
    case (op_q)
      OpRead:  match = rd_done_i;
      OpProg:  match = prog_done_i;
      default: match = erase_done_i;
    endcase
  end

  assign busy_o      = (state_q != StIdle);
  assign req_addr_o  = addr_q[AW-1:WordW];
  assign req_bk_o    = addr_q[AW-1 -: BankW];
  assign addr_ovfl_o = ovfl_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    hst_gnt_o    = 1'b0;
    ctrl_gnt_o   = 1'b0;
    hst_done_o   = 1'b0;
    hst_err_o    = 1'b0;
    ctrl_done_o  = 1'b0;
    ctrl_err_o   = 1'b0;
    ctrl_wdone_o = 1'b0;
    req_o        = 1'b0;
    rd_o         = 1'b0;
    prog_o       = 1'b0;
    pg_erase_o   = 1'b0;
    bk_erase_o   = 1'b0;
    case (state_q)
      StIdle: begin
        if (hst_req_i || ctrl_req_i) state_d = StGrant;
      end
      StGrant: begin
        hst_gnt_o  = host_sel_q;
        ctrl_gnt_o = !host_sel_q;
        state_d    = (!host_sel_q && bad_req) ? StFin : StIssue;
      end
      StIssue: begin
        req_o      = 1'b1;
        rd_o       = (op_q == OpRead);
        prog_o     = (op_q == OpProg);
        pg_erase_o = (op_q == OpErase) && !erase_bk_q;
        bk_erase_o = (op_q == OpErase) && erase_bk_q;
        if (match) begin
          ctrl_wdone_o = !host_sel_q && (op_q != OpErase);
          state_d      = (error_i || last_word) ? StFin : StNext;
        end else if (timeout) begin
          state_d = StFin;
        end
      end
      StNext: state_d = StIssue;
      StFin: begin
        hst_done_o  = host_sel_q;
        hst_err_o   = host_sel_q && err_q;
        ctrl_done_o = !host_sel_q;
        ctrl_err_o  = !host_sel_q && err_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand latching, word sequencing, watchdog and sticky error/overflow tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_sel_q <= 1'b0;
      op_q       <= OpRead;
      erase_bk_q <= 1'b0;
      addr_q     <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      ovfl_q     <= 1'b0;
`ifdef FLASH_ARB_RR_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: host_sel_q <= pick_host;
        StGrant: begin
          err_q  <= !host_sel_q && bad_req;
          ovfl_q <= 1'b0;
          cnt_q  <= '0;
          wdog_q <= '0;
`ifdef FLASH_ARB_RR_EN
          rr_ptr_q <= host_sel_q;
`endif
          if (host_sel_q) begin
            addr_q     <= hst_addr_i;
            op_q       <= OpRead;
            num_q      <= '0;
            erase_bk_q <= 1'b0;
          end else begin
            addr_q     <= ctrl_addr_i;
            op_q       <= ctrl_op_i;
            num_q      <= ctrl_num_i;
            erase_bk_q <= ctrl_erase_sel_i;
          end
        end
        StIssue: begin
          if (match)         err_q  <= err_q | error_i;
          else if (timeout)  err_q  <= 1'b1;
          else               wdog_q <= wdog_q + TimeoutW'(1);
        end
        StNext: begin
          // A carry out of the top address bit marks every remaining issue as overflowed.
          addr_q <= addr_inc[AW-1:0];
          ovfl_q <= ovfl_q | addr_inc[AW];
          cnt_q  <= cnt_q + (WordW+1)'(1);
          wdog_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_op_arb.sv
// Randomized self-checking bench for flash_op_arb; expected issue sequences, grant order
// and completion status come from a sequence-level model of each requested op.
module tb_flash_op_arb;

  localparam int AW         = 17;
  localparam int WordW      = 8;
  localparam int WdogCycles = 4095;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             hst_req_i;
  logic [AW-1:0]    hst_addr_i;
  logic             hst_gnt_o, hst_done_o, hst_err_o;
  logic             ctrl_req_i;
  logic [1:0]       ctrl_op_i;
  logic             ctrl_erase_sel_i;
  logic [AW-1:0]    ctrl_addr_i;
  logic [WordW:0]   ctrl_num_i;
  logic             ctrl_gnt_o, ctrl_wdone_o, ctrl_done_o, ctrl_err_o;
  logic             busy_o, req_o, addr_ovfl_o;
  logic [8:0]       req_addr_o;
  logic [0:0]       req_bk_o;
  logic             rd_o, prog_o, pg_erase_o, bk_erase_o;
  logic             rd_done_i, prog_done_i, erase_done_i, error_i;

  always #5 clk_i = ~clk_i;

  flash_op_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .hst_req_i(hst_req_i), .hst_addr_i(hst_addr_i), .hst_gnt_o(hst_gnt_o),
    .hst_done_o(hst_done_o), .hst_err_o(hst_err_o),
    .ctrl_req_i(ctrl_req_i), .ctrl_op_i(ctrl_op_i), .ctrl_erase_sel_i(ctrl_erase_sel_i),
    .ctrl_addr_i(ctrl_addr_i), .ctrl_num_i(ctrl_num_i), .ctrl_gnt_o(ctrl_gnt_o),
    .ctrl_wdone_o(ctrl_wdone_o), .ctrl_done_o(ctrl_done_o), .ctrl_err_o(ctrl_err_o),
    .busy_o(busy_o), .req_o(req_o), .req_addr_o(req_addr_o), .req_bk_o(req_bk_o),
    .addr_ovfl_o(addr_ovfl_o), .rd_o(rd_o), .prog_o(prog_o), .pg_erase_o(pg_erase_o),
    .bk_erase_o(bk_erase_o), .rd_done_i(rd_done_i), .prog_done_i(prog_done_i),
    .erase_done_i(erase_done_i), .error_i(error_i)
  );

  int checks = 0;
  int errors = 0;
  int wdoneCnt = 0, reqCycles = 0, hostDoneCnt = 0;

  // Model state: operands currently presented on each port and the last granted port.
  logic [AW-1:0]  hAddr, cAddr;
  logic [1:0]     cOp;
  logic           cEsel;
  logic [WordW:0] cNum;
  bit             lastGrantHost = 1'b0;

  always @(negedge clk_i) begin
    if (ctrl_wdone_o) wdoneCnt++;
    if (req_o)        reqCycles++;
    if (hst_done_o)   hostDoneCnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not end, got running expected finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setHost(input logic [AW-1:0] addr);
    hAddr = addr;
    hst_addr_i = addr;
  endtask

  task automatic setCtrl(input logic [1:0] op, input logic esel, input logic [AW-1:0] addr,
                         input logic [WordW:0] num);
    cOp = op; cEsel = esel; cAddr = addr; cNum = num;
    ctrl_op_i = op; ctrl_erase_sel_i = esel; ctrl_addr_i = addr; ctrl_num_i = num;
  endtask

  task automatic recover();
    rst_ni = 1'b0;
    hst_req_i = 1'b0; ctrl_req_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    lastGrantHost = 1'b0;
    tick();
  endtask

  task automatic waitGnt(input bit expHost, output bit gotHost, output bit ok);
    int n = 0;
    ok = 1'b0;
    gotHost = expHost;
    while (n < 20 && !ok) begin
      tick();
      n++;
      if (hst_gnt_o || ctrl_gnt_o) ok = 1'b1;
    end
    checkOutput("gnt_seen", ok, 1);
    if (ok) begin
      checkOutput("gnt_host", hst_gnt_o, expHost);
      checkOutput("gnt_ctrl", ctrl_gnt_o, !expHost);
      gotHost = hst_gnt_o;
      lastGrantHost = gotHost;
      if (gotHost) hst_req_i = 1'b0;
      else         ctrl_req_i = 1'b0;
    end
  endtask

  // Acts as the MP stage for one granted op; called on the grant cycle.
  task automatic serveOp(input bit isHost, input int errIdxIn, input int fixedDelay, input bit inject);
    logic [1:0] op;
    logic [AW-1:0] base;
    logic [3:0] expLines, lines;
    bit bad, expErr, wdoneKnown;
    int nIss, issues, errIdx, d, sum, page, w0, r0, reqSum, expWdone;
    op   = isHost ? 2'd0 : cOp;
    base = isHost ? hAddr : cAddr;
    bad  = !isHost && (cOp == 2'd3 || (cOp != 2'd2 && cNum > 255));
    if (bad)                        nIss = 0;
    else if (isHost || op == 2'd2)  nIss = 1;
    else                            nIss = int'(cNum) + 1;
    errIdx = (errIdxIn < nIss) ? errIdxIn : -1;
    issues = (errIdx >= 0) ? errIdx + 1 : nIss;
    expErr = bad || (errIdx >= 0);
    expLines = (op == 2'd0) ? 4'b1000 : (op == 2'd1) ? 4'b0100 : (cEsel ? 4'b0001 : 4'b0010);
    wdoneKnown = bad || isHost || op == 2'd2 || errIdx < 0;
    expWdone = (bad || isHost || op == 2'd2) ? 0 : nIss;
    w0 = wdoneCnt; r0 = reqCycles; reqSum = 0;
    for (int i = 0; i < issues; i++) begin
      tick();
      sum  = int'(base) + i;
      page = (sum % (1 << AW)) >> WordW;
      lines = {rd_o, prog_o, pg_erase_o, bk_erase_o};
      checkOutput("issue_req", req_o, 1);
      checkOutput("issue_op", lines, expLines);
      checkOutput("issue_page", req_addr_o, page);
      checkOutput("issue_bank", req_bk_o, page >> 8);
      checkOutput("issue_ovfl", addr_ovfl_o, sum >= (1 << AW));
      d = (fixedDelay >= 0) ? fixedDelay : $urandom_range(0, 3);
      for (int j = 0; j < d; j++) begin
        if (inject && $urandom_range(0, 1) == 1) begin
          case (op)
            2'd0:    if ($urandom_range(0, 1) == 1) prog_done_i = 1'b1; else erase_done_i = 1'b1;
            2'd1:    if ($urandom_range(0, 1) == 1) rd_done_i = 1'b1; else erase_done_i = 1'b1;
            default: if ($urandom_range(0, 1) == 1) rd_done_i = 1'b1; else prog_done_i = 1'b1;
          endcase
        end
        tick();
        rd_done_i = 1'b0; prog_done_i = 1'b0; erase_done_i = 1'b0;
      end
      case (op)
        2'd0:    rd_done_i = 1'b1;
        2'd1:    prog_done_i = 1'b1;
        default: erase_done_i = 1'b1;
      endcase
      error_i = (i == errIdx);
      reqSum += d + 1;
      tick();
      rd_done_i = 1'b0; prog_done_i = 1'b0; erase_done_i = 1'b0; error_i = 1'b0;
      if (i < issues - 1) checkOutput("next_gap", req_o, 0);
    end
    if (issues == 0) tick();
    if (isHost) begin
      checkOutput("hst_done", hst_done_o, 1);
      checkOutput("hst_err", hst_err_o, expErr);
      checkOutput("ctrl_done_quiet", ctrl_done_o, 0);
    end else begin
      checkOutput("ctrl_done", ctrl_done_o, 1);
      checkOutput("ctrl_err", ctrl_err_o, expErr);
      checkOutput("hst_done_quiet", hst_done_o, 0);
    end
    checkOutput("req_cycles", reqCycles - r0, reqSum);
    if (wdoneKnown) checkOutput("wdone_count", wdoneCnt - w0, expWdone);
    tick();
    checkOutput("busy_idle", busy_o, 0);
  endtask

  // Raises the selected requests together and serves them in the order the arbiter rules give.
  task automatic applyStimulus(input bit wantHost, input bit wantCtrl, input int hErr, input int cErr,
                               input int delay, input bit inject);
    bit firstHost, got, ok;
    if (!wantHost && !wantCtrl) return;
`ifdef FLASH_ARB_RR_EN
    firstHost = wantHost && (!wantCtrl || !lastGrantHost);
`else
    firstHost = wantHost;
`endif
    hst_req_i  = wantHost;
    ctrl_req_i = wantCtrl;
    waitGnt(firstHost, got, ok);
    if (!ok) begin recover(); return; end
    serveOp(got, got ? hErr : cErr, delay, inject);
    if (wantHost && wantCtrl) begin
      waitGnt(!got, got, ok);
      if (!ok) begin recover(); return; end
      serveOp(got, got ? hErr : cErr, delay, inject);
    end
  endtask

  initial begin
    bit got, ok;
    int n, r0, h0, sel, r;
    logic [1:0] op;
    logic [WordW:0] num;
    logic [AW-1:0] addr;

    rst_ni = 1'b0;
    hst_req_i = 1'b0; ctrl_req_i = 1'b0;
    setHost('0); setCtrl(2'd0, 1'b0, '0, '0);
    rd_done_i = 1'b0; prog_done_i = 1'b0; erase_done_i = 1'b0; error_i = 1'b0;
    tick(); tick();
    checkOutput("rst_req", req_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_gnts", {hst_gnt_o, ctrl_gnt_o}, 0);
    checkOutput("rst_dones", {hst_done_o, ctrl_done_o, ctrl_wdone_o}, 0);
    checkOutput("rst_ovfl", addr_ovfl_o, 0);
    checkOutput("rst_addr", req_addr_o, 0);
    rst_ni = 1'b1;
    tick();

    $display("[TB] host read, three-cycle response");
    setHost(17'h12345);
    applyStimulus(1, 0, -1, -1, 2, 0);

    $display("[TB] controller program across a page boundary");
    setCtrl(2'd1, 1'b0, 17'h010FE, 9'd3);
    applyStimulus(0, 1, -1, -1, -1, 1);

    $display("[TB] controller bank erase");
    setCtrl(2'd2, 1'b1, 17'h10000 | 17'($urandom_range(0, 16'hFFFF)), 9'd7);
    applyStimulus(0, 1, -1, -1, -1, 1);

    $display("[TB] controller read wrapping the address space");
    setCtrl(2'd0, 1'b0, 17'h1FFFF, 9'd1);
    applyStimulus(0, 1, -1, 1, -1, 0);

    $display("[TB] illegal op and oversized count");
    setCtrl(2'd3, 1'b0, 17'h00100, 9'd0);
    applyStimulus(0, 1, -1, -1, -1, 0);
    setCtrl(2'd1, 1'b0, 17'h00100, 9'd300);
    applyStimulus(0, 1, -1, -1, -1, 0);

    $display("[TB] simultaneous requests");
    setHost(17'h00ABC); setCtrl(2'd0, 1'b0, 17'h00200, 9'd0);
    applyStimulus(1, 1, -1, -1, -1, 0);
    setHost(17'h1F0F0); setCtrl(2'd1, 1'b0, 17'h00300, 9'd1);
    applyStimulus(1, 1, -1, -1, -1, 0);

    $display("[TB] randomized ops");
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 2);
      setHost(17'($urandom));
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      num = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 4));
      addr = ($urandom_range(0, 3) == 0) ? 17'h1FFFF - 17'($urandom_range(0, 3)) : 17'($urandom);
      setCtrl(op, 1'($urandom_range(0, 1)), addr, num);
      applyStimulus(sel != 1, sel != 0,
                    ($urandom_range(0, 4) == 0) ? 0 : -1,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1,
                    -1, 1);
    end

    $display("[TB] watchdog abort");
    setCtrl(2'd0, 1'b0, 17'h00400, 9'd0);
    ctrl_req_i = 1'b1;
    waitGnt(0, got, ok);
    if (ok) begin
      r0 = reqCycles;
      n = 0;
      while (n < 5000 && !ctrl_done_o) begin
        tick();
        n++;
      end
      checkOutput("wdog_done_seen", ctrl_done_o, 1);
      checkOutput("wdog_err", ctrl_err_o, 1);
      checkOutput("wdog_len_ok", ((reqCycles - r0) >= WdogCycles) && ((reqCycles - r0) <= WdogCycles + 1), 1);
      tick();
    end else recover();

    $display("[TB] reset during issue");
    setHost(17'h0ABCD);
    hst_req_i = 1'b1;
    waitGnt(1, got, ok);
    if (ok) begin
      tick();
      checkOutput("rst_mid_pre_req", req_o, 1);
      h0 = hostDoneCnt;
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_mid_req", req_o, 0);
      checkOutput("rst_mid_rd", rd_o, 0);
      checkOutput("rst_mid_busy", busy_o, 0);
      tick(); tick();
      rst_ni = 1'b1;
      lastGrantHost = 1'b0;
      rd_done_i = 1'b1;
      tick();
      rd_done_i = 1'b0;
      repeat (3) tick();
      checkOutput("rst_mid_no_done", hostDoneCnt - h0, 0);
      checkOutput("rst_mid_idle", busy_o, 0);
    end else recover();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
